mux_scan_ctrl: RTL and testbench
================================

# mux_scan_ctrl

Scan sequencer paired with the 2-bit 4:1 channel mux. It drives the mux select and steps through the enabled channels, holding each for a programmable dwell time. At the end of each dwell it samples the mux output and packs the four 2-bit channel values into one 8-bit frame. The frame is delivered downstream over a valid/ready handshake, so this block both feeds the mux (select) and consumes what the mux produces (data).

## Interface
Parameters:
- DWELL, default 4: cycles each channel is selected before sampling; legal range 1–255.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a scan; honoured only in IDLE.
- mode  in  1  0 = single frame, 1 = continuous; latched with start.
- mask  in  4  channel enable, bit k enables channel k; latched with start.
- stop  in  1  in continuous mode, finish the current frame and then return to IDLE.
- sel  out  2  select to the mux s input.
- mux_o  in  2  mux output o.
- frame  out  8  channel k is in bits [2k+1:2k]; disabled channels read 00.
- frame_valid  out  1  frame is available downstream.
- frame_ready  in  1  downstream accepts the frame.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, SCAN, PRESENT.
- Reset (asynchronous, while rst_n = 0):
  - sel = 00, frame = 00h, frame_valid = 0, busy = 0.
  - Internal: state IDLE, dwell count 0, shadow 00h, latched mask 0000, latched mode 0, stop flag 0.
- IDLE → SCAN when start = 1 and mask ≠ 0000:
  - Latch mask and mode; clear the shadow register and stop flag.
  - sel = lowest set bit of mask; dwell count = 0.
- IDLE with start = 1 and mask = 0000: ignored; stays in IDLE, no frame is produced.
- start is ignored in SCAN and PRESENT.
- SCAN:
  - Dwell count increments each cycle.
  - On the cycle where count = DWELL-1, mux_o is written to shadow slot sel and the count clears.
  - If a higher enabled channel exists, sel moves to the next higher set bit on that same edge (no gap cycle); otherwise → PRESENT.
- SCAN → PRESENT: on the last sample edge, frame takes the shadow value including the new sample, and frame_valid = 1.
- sel holds its last value in PRESENT and in IDLE.
- PRESENT:
  - frame and frame_valid hold stable until frame_ready = 1.
  - The transfer happens on the edge where valid and ready are both high; on that edge frame_valid → 0.
  - Single mode, or stop flag set: → IDLE, busy → 0.
  - Continuous mode: → SCAN; shadow is cleared, sel = lowest enabled channel, count = 0. The latched mask is reused.
- stop: sampled in any non-IDLE state and sets the stop flag; it has no effect in IDLE. The current frame still completes and transfers.
- frame keeps the last delivered value after the transfer until the next frame loads.

## Timing
- start sampled at edge E0: sel is valid after E0.
- With N enabled channels, frame_valid rises at edge E0 + N·DWELL.
- Channel k is sampled at the end of its DWELL-th cycle. The mux is combinational, so no extra settle time is required.
- Continuous mode: the next frame_valid rises N·DWELL edges after the transfer edge.
- Throughput, with frame_ready held high: one frame per N·DWELL cycles plus one PRESENT cycle.
- Reset in mid-scan or in PRESENT: outputs go to their reset values immediately; the partial frame is discarded.

## Test plan
Bench instantiates the mux with i0 = 01, i1 = 10, i2 = 11, i3 = 00; DWELL = 4 unless stated.
- Full scan: mask 1111, mode 0, frame_ready = 1.
  - Required: sel sequence 0,1,2,3, four cycles each.
  - frame_valid pulses one cycle at E0 + 16 with frame = 39h; busy drops on the transfer edge.
- Sparse mask: mask 0101.
  - Required: sel 0 then 2; frame = 31h at E0 + 8.
  - A repeat with mask 1000 gives frame = 00h at E0 + 4, sel = 3.
- Backpressure: mask 1111, frame_ready = 0 for 10 cycles after valid.
  - Required: frame = 39h, frame_valid = 1 and sel = 3 stay stable throughout.
  - Transfer on the first ready edge; start pulses issued during the wait are ignored.
- Continuous and stop: mode 1, mask 0011.
  - Required: frame = 09h, then change i0 to 11 → next frame = 0Bh.
  - Assert stop during the second scan: the second frame still transfers, then IDLE with busy = 0.
- Reset and corner cases:
  - Reset at cycle 6 of a mask-1111 scan: sel = 00, frame = 00h, frame_valid = 0 immediately, no frame afterward.
  - start with mask 0000: busy stays 0.
  - DWELL = 1, mask 1111: frame = 39h at E0 + 4.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: scan sequencer for a 2-bit 4:1 channel mux.
//
// Drives the mux select through every channel enabled in a latched mask, holding each
// for DWELL cycles. On the last cycle of each dwell it samples the mux output into a
// shadow frame. Once every enabled channel has been sampled, it presents the packed
// 8-bit frame downstream over a valid/ready handshake.
//
// Parameters:
//   DWELL        cycles each channel stays selected before it is sampled (1..255)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        one-cycle scan request, honoured only while idle
//   mode         0 = single frame, 1 = continuous (latched with start)
//   mask         channel enables, bit k enables channel k (latched with start)
//   stop         in continuous mode, finish the current frame and then go idle
//   sel          select to the mux
//   mux_o        mux output
//   frame        packed frame, channel k in bits [2k+1:2k]; disabled channels read 00
//   frame_valid  frame is available downstream
//   frame_ready  downstream accepts the frame
//   busy         high whenever the sequencer is not idle
module mux_scan_ctrl #(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode,
  input  logic [3:0] mask,
  input  logic       stop,
  output logic [1:0] sel,
  input  logic [1:0] mux_o,
  output logic [7:0] frame,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic       busy
);

  // Dwell counter terminal value; the sample happens on the edge that ends this count.
  localparam logic [7:0] DwellLast = 8'(DWELL - 1);

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StPresent
  } state_e;

  state_e     state_q, state_d;

  logic [7:0] count_q, count_d;
  logic [7:0] shadow_q, shadow_d;
  logic [7:0] frame_q, frame_d;
  logic [3:0] mask_q, mask_d;
  logic       mode_q, mode_d;
  logic       stop_q, stop_d;
  logic [1:0] sel_q, sel_d;

  logic       launch;
  logic       sample_now;
  logic       xfer;
  logic       rescan;
  logic       has_next;
  logic [1:0] next_sel;

  // Index of the lowest set bit; only called with a non-zero mask.
  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    logic [1:0] idx;
    idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (m[k]) begin
        idx = 2'(k);
      end
    end
    return idx;
  endfunction

  // Next enabled channel above the current select. Scanning downward leaves the
  // closest higher channel as the final assignment.
  always_comb begin
    has_next = 1'b0;
    next_sel = sel_q;
    for (int k = 3; k >= 0; k--) begin
      if (mask_q[k] && (k > int'(sel_q))) begin
        has_next = 1'b1;
        next_sel = 2'(k);
      end
    end
  end

  assign launch     = (state_q == StIdle) && start && (mask != 4'b0000);
  assign sample_now = (state_q == StScan) && (count_q == DwellLast);
  assign xfer       = (state_q == StPresent) && frame_ready;
  // A stop arriving on the transfer edge itself also ends the run.
  assign rescan     = xfer && mode_q && !stop_q && !stop;

  //--------------------------------------------------------------------------
  // FSM: state register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: next-state logic
  //--------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (launch) begin
          state_d = StScan;
        end
      end
      StScan: begin
        if (sample_now && !has_next) begin
          state_d = StPresent;
        end
      end
      StPresent: begin
        if (xfer) begin
          state_d = rescan ? StScan : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  //--------------------------------------------------------------------------
  // FSM: outputs
  //--------------------------------------------------------------------------
  always_comb begin
    sel         = sel_q;
    frame       = frame_q;
    frame_valid = (state_q == StPresent);
    busy        = (state_q != StIdle);
  end

  //--------------------------------------------------------------------------
  // Datapath next-state
  //--------------------------------------------------------------------------
  always_comb begin
    count_d  = count_q;
    shadow_d = shadow_q;
    frame_d  = frame_q;
    mask_d   = mask_q;
    mode_d   = mode_q;
    stop_d   = stop_q;
    sel_d    = sel_q;

    if (launch) begin
      mask_d   = mask;
      mode_d   = mode;
      stop_d   = 1'b0;
      shadow_d = 8'h00;
      count_d  = 8'd0;
      sel_d    = lowest_set(mask);
    end

    if ((state_q != StIdle) && stop) begin
      stop_d = 1'b1;
    end

    if (state_q == StScan) begin
      if (sample_now) begin
        shadow_d[{sel_q, 1'b0} +: 2] = mux_o;
        count_d = 8'd0;
        // Move straight to the next channel with no gap cycle; on the last one the
        // frame captures the shadow including the sample just taken.
        if (has_next) begin
          sel_d = next_sel;
        end else begin
          frame_d = shadow_d;
        end
      end else begin
        count_d = count_q + 8'd1;
      end
    end

    // Continuous restart reuses the latched mask.
    if (rescan) begin
      shadow_d = 8'h00;
      count_d  = 8'd0;
      sel_d    = lowest_set(mask_q);
    end
  end

  //--------------------------------------------------------------------------
  // Datapath registers
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 8'd0;
      shadow_q <= 8'h00;
      frame_q  <= 8'h00;
      mask_q   <= 4'b0000;
      mode_q   <= 1'b0;
      stop_q   <= 1'b0;
      sel_q    <= 2'd0;
    end else begin
      count_q  <= count_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      mask_q   <= mask_d;
      mode_q   <= mode_d;
      stop_q   <= stop_d;
      sel_q    <= sel_d;
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Testbench for mux_scan_ctrl: a transaction-level reference model driven by the same
// stimulus is compared against the DUT on every falling edge, alongside directed
// scenarios with hand-computed frame values and latencies. A second instance with
// DWELL = 1 covers the shortest dwell.
module tb_mux_scan_ctrl;

  localparam int DW = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic       stop = 1'b0;
  logic       frame_ready = 1'b0;
  logic [3:0] mask = 4'b0000;
  logic [1:0] sel;
  logic [1:0] mux_o;
  logic [7:0] frame;
  logic       frame_valid;
  logic       busy;

  logic       start1 = 1'b0;
  logic       ready1 = 1'b0;
  logic [1:0] sel1;
  logic [1:0] mux_o1;
  logic [7:0] frame1;
  logic       valid1;
  logic       busy1;

  // Mux inputs i0..i3
  logic [1:0] chan [4];

  int errors = 0;
  int checks = 0;

  assign mux_o  = chan[sel];
  assign mux_o1 = chan[sel1];

  always #5 clk = ~clk;

  mux_scan_ctrl #(.DWELL(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mode        (mode),
    .mask        (mask),
    .stop        (stop),
    .sel         (sel),
    .mux_o       (mux_o),
    .frame       (frame),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .busy        (busy)
  );

  mux_scan_ctrl #(.DWELL(1)) dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start1),
    .mode        (1'b0),
    .mask        (4'b1111),
    .stop        (1'b0),
    .sel         (sel1),
    .mux_o       (mux_o1),
    .frame       (frame1),
    .frame_valid (valid1),
    .frame_ready (ready1),
    .busy        (busy1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a scan is a list of enabled channels; elapsed scan cycle t
  // selects channel list[t / DW], and channel list[j] is sampled on the edge
  // that completes cycle (j + 1) * DW.
  // ---------------------------------------------------------------------------
  int         m_phase = 0;  // 0 idle, 1 scanning, 2 presenting
  int         m_t = 0;
  int         m_n = 0;
  int         m_j = 0;
  int         m_ch [4];
  bit         m_mode = 1'b0;
  bit         m_stop = 1'b0;
  logic [7:0] m_shadow = 8'h00;
  logic [7:0] m_frame = 8'h00;
  logic [1:0] m_sel = 2'd0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_phase = 0; m_t = 0; m_n = 0; m_mode = 1'b0; m_stop = 1'b0;
        m_shadow = 8'h00; m_frame = 8'h00; m_sel = 2'd0;
      end else begin
        case (m_phase)
          0: begin
            if (start && (mask != 4'b0000)) begin
              m_n = 0;
              for (int k = 0; k < 4; k++) begin
                if (mask[k]) begin
                  m_ch[m_n] = k;
                  m_n++;
                end
              end
              m_mode = mode; m_stop = 1'b0; m_shadow = 8'h00; m_t = 0; m_phase = 1;
              m_sel = 2'(m_ch[0]);
            end
          end
          1: begin
            if (stop) m_stop = 1'b1;
            m_t++;
            if ((m_t % DW) == 0) begin
              m_j = (m_t / DW) - 1;
              m_shadow[2 * m_ch[m_j] +: 2] = chan[m_ch[m_j]];
              if (m_j == m_n - 1) begin
                m_frame = m_shadow;
                m_phase = 2;
              end else begin
                m_sel = 2'(m_ch[m_j + 1]);
              end
            end
          end
          default: begin
            if (stop) m_stop = 1'b1;
            if (frame_ready) begin
              if (!m_mode || m_stop) begin
                m_phase = 0;
              end else begin
                m_shadow = 8'h00; m_t = 0; m_phase = 1; m_sel = 2'(m_ch[0]);
              end
            end
          end
        endcase
      end
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      chk("sel", 32'(sel), 32'(m_sel));
      chk("frame", 32'(frame), 32'(m_frame));
      chk("frame_valid", 32'(frame_valid), 32'(m_phase == 2));
      chk("busy", 32'(busy), 32'(m_phase != 0));
    end
  end

  task automatic pulse_start(input logic [3:0] m, input logic md);
    @(negedge clk);
    start = 1'b1; mask = m; mode = md;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts falling edges after the start edge until frame_valid is seen.
  task automatic wait_valid(input int limit, output int cnt);
    cnt = 1;
    while (!frame_valid && cnt < limit) begin
      @(negedge clk);
      cnt++;
    end
    chk("valid_seen", 32'(frame_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int c2;
    int seen;
    int idx;

    chan[0] = 2'b01; chan[1] = 2'b10; chan[2] = 2'b11; chan[3] = 2'b00;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_frame", 32'(frame), 32'h00);
    chk("rst_valid", 32'(frame_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Full scan, single mode
    frame_ready = 1'b1;
    pulse_start(4'b1111, 1'b0);
    wait_valid(40, cnt);
    chk("full_latency", 32'(cnt), 32'd17);
    chk("full_frame", 32'(frame), 32'h39);
    chk("model_full_frame", 32'(m_frame), 32'h39);
    @(negedge clk);
    chk("full_valid_drop", 32'(frame_valid), 32'd0);
    chk("full_busy_drop", 32'(busy), 32'd0);
    chk("full_frame_hold", 32'(frame), 32'h39);

    // Sparse masks
    pulse_start(4'b0101, 1'b0);
    wait_valid(40, cnt);
    chk("sparse_latency", 32'(cnt), 32'd9);
    chk("sparse_frame", 32'(frame), 32'h31);
    chk("sparse_sel", 32'(sel), 32'd2);
    @(negedge clk);
    pulse_start(4'b1000, 1'b0);
    wait_valid(40, cnt);
    chk("ch3_latency", 32'(cnt), 32'd5);
    chk("ch3_frame", 32'(frame), 32'h00);
    chk("ch3_sel", 32'(sel), 32'd3);
    @(negedge clk);

    // Backpressure, with start pulses that must be ignored
    frame_ready = 1'b0;
    pulse_start(4'b1111, 1'b0);
    wait_valid(40, cnt);
    chk("bp_latency", 32'(cnt), 32'd17);
    for (int i = 0; i < 10; i++) begin
      chk("bp_frame", 32'(frame), 32'h39);
      chk("bp_valid", 32'(frame_valid), 32'd1);
      chk("bp_sel", 32'(sel), 32'd3);
      if (i == 3) begin
        start = 1'b1; mask = 4'b0001;
      end
      if (i == 4) start = 1'b0;
      @(negedge clk);
    end
    frame_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_drop", 32'(frame_valid), 32'd0);
    chk("bp_busy_drop", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("bp_start_ignored", 32'(busy), 32'd0);

    // Continuous mode with stop during the second scan
    pulse_start(4'b0011, 1'b1);
    wait_valid(40, cnt);
    chk("cont_latency", 32'(cnt), 32'd9);
    chk("cont_frame1", 32'(frame), 32'h09);
    chan[0] = 2'b11;
    c2 = 0;
    do begin
      @(negedge clk);
      c2++;
      stop = (c2 == 3);
    end while (!frame_valid && c2 < 30);
    stop = 1'b0;
    chk("cont_gap", 32'(c2), 32'd9);
    chk("cont_frame2", 32'(frame), 32'h0B);
    @(negedge clk);
    chk("cont_stop_busy", 32'(busy), 32'd0);
    chk("cont_stop_valid", 32'(frame_valid), 32'd0);
    chan[0] = 2'b01;

    // Reset in mid-scan
    pulse_start(4'b1111, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_sel", 32'(sel), 32'd0);
    chk("midrst_frame", 32'(frame), 32'h00);
    chk("midrst_valid", 32'(frame_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (frame_valid) seen++;
    end
    chk("midrst_no_frame", 32'(seen), 32'd0);

    // Start with an empty mask
    pulse_start(4'b0000, 1'b0);
    repeat (3) begin
      chk("empty_mask_busy", 32'(busy), 32'd0);
      @(negedge clk);
    end

    // DWELL = 1 instance
    @(negedge clk);
    start1 = 1'b1; ready1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    cnt = 1;
    while (!valid1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("d1_latency", 32'(cnt), 32'd5);
    chk("d1_frame", 32'(frame1), 32'h39);
    @(negedge clk);
    chk("d1_busy_drop", 32'(busy1), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      start       = ($urandom_range(0, 7) == 0);
      mask        = 4'($urandom);
      mode        = 1'($urandom);
      stop        = ($urandom_range(0, 15) == 0);
      frame_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 19) == 0) begin
        idx = int'($urandom_range(0, 3));
        chan[idx] = 2'($urandom);
      end
    end
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
